// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM encoding, parity-type constants and width default for the UART transmitter
package uart_tx_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: holds the captured payload and the bit counter; presents the bit for the next line cycle
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ser_data,
    output logic                  ser_done,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    assign ser_done = (cnt_q == CW'(DATA_WIDTH - 1));
    // The line register is loaded from the next state, so the bit offered is the one the counter moves to
    assign ser_data = data_q[cnt_d];
    assign data_out = data_q;

    // Load captures the payload and rewinds; each DATA cycle advances the counter, wrapping after the last bit
    always_comb begin
        data_d = load ? data_in : data_q;
        cnt_d  = load ? '0 : (shift ? (ser_done ? '0 : cnt_q + 1'b1) : cnt_q);
    end

    // Payload and counter registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: framed serial transmitter (start, LSB-first data, optional parity, stop) with registered line and busy
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    state_e                state_q, state_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  load, shift, ser_data, ser_done, parity;
    logic [DATA_WIDTH-1:0] data_reg;

    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .data_in  (P_DATA),
        .ser_data (ser_data),
        .ser_done (ser_done),
        .data_out (data_reg)
    );

    assign shift  = (state_q == DATA);
    assign parity = (par_typ_q == PAR_EVEN) ? ^data_reg : ~^data_reg;
    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

    // Next state plus line/busy values for the state being entered, so outputs line up with the state
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    state_d   = START;
                    load      = 1'b1;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                end
            end
            START:   state_d = DATA;
            DATA:    state_d = ser_done ? (par_en_q ? PARITY : STOP) : DATA;
            PARITY:  state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = ser_data;
            PARITY:  tx_d = parity;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any frame and idles the line high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the payload bits per frame.
REQ-002 SHALL have port clk, input, 1 bit: the bit-rate clock; exactly one serial bit is driven per clk cycle.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port P_DATA, input, DATA_WIDTH bits: parallel payload.
REQ-005 SHALL have port Data_Valid, input, 1 bit: request to send P_DATA.
REQ-006 SHALL have port PAR_EN, input, 1 bit: 1 inserts a parity bit.
REQ-007 SHALL have port PAR_TYP, input, 1 bit: 0 selects even parity, 1 selects odd parity.
REQ-008 SHALL have port TX_OUT, output, 1 bit: registered serial line, idle high.
REQ-009 SHALL have port Busy, output, 1 bit: registered, high while a frame is in progress.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-011 SHALL, in IDLE, accept a request when Data_Valid=1 at a clk edge: capture P_DATA, PAR_EN and PAR_TYP, then go to START.
REQ-012 SHALL ignore Data_Valid in every state other than IDLE; requests made while Busy=1 are dropped, not queued.
REQ-013 SHALL drive TX_OUT=0 for exactly one cycle in START, starting the cycle after the acceptance edge (latency 1 cycle).
REQ-014 SHALL, in DATA, send the captured bits LSB first, one per cycle, for DATA_WIDTH cycles, using a counter that runs 0..DATA_WIDTH-1.
REQ-015 SHALL go from DATA to PARITY when the counter reaches DATA_WIDTH-1 and the captured PAR_EN=1; otherwise it SHALL go to STOP.
REQ-016 SHALL drive the parity bit in PARITY for one cycle: XOR-reduction of the captured data when PAR_TYP=0, its inverse when PAR_TYP=1.
REQ-017 SHALL drive TX_OUT=1 for one cycle in STOP, then return to IDLE.
REQ-018 SHALL produce a frame length of DATA_WIDTH+2 cycles without parity and DATA_WIDTH+3 cycles with parity.
REQ-019 SHALL hold TX_OUT=1 in IDLE.
REQ-020 SHALL hold Busy=1 for exactly the START, DATA, PARITY and STOP cycles, aligned with TX_OUT, and Busy=0 in IDLE.
REQ-021 SHALL guarantee at least one IDLE cycle between frames, so the earliest next acceptance is the edge ending the first IDLE cycle.
REQ-022 SHALL ignore changes on P_DATA, PAR_EN and PAR_TYP after acceptance until the frame ends.
REQ-023 SHALL keep TX_OUT glitch-free by driving it from a flop only.

Reset
REQ-024 SHALL, when rst=0, asynchronously force: state=IDLE, TX_OUT=1, Busy=0, bit counter=0, data register=0.
REQ-025 SHALL abort any frame in progress on reset with no completion; after rst deasserts, the block SHALL accept on the first edge with Data_Valid=1.

Structure
REQ-026 SHALL place the FSM state encoding, the parity-type constants (EVEN=0, ODD=1) and the DATA_WIDTH default in shared package uart_tx_pkg.
REQ-027 SHALL use one sub-module, uart_tx_serializer, holding the load/shift register and the bit counter, with outputs ser_data and ser_done to the FSM.
REQ-028 SHALL compute parity in the top level from the captured data register.

Verification
REQ-029 SHALL cover: P_DATA=0xA5, PAR_EN=0, one-cycle Data_Valid -> TX_OUT 0,1,0,1,0,0,1,0,1,1 over 10 cycles, Busy high for those 10 cycles.
REQ-030 SHALL cover: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0, 11-cycle frame; with PAR_TYP=1 -> parity bit 1.
REQ-031 SHALL cover: P_DATA=0x00, PAR_EN=1, PAR_TYP=1 -> 0, eight 0s, 1, 1.
REQ-032 SHALL cover: Data_Valid asserted with P_DATA=0xFF during cycle 4 of a 0x3C frame -> 0x3C frame unchanged, no 0xFF frame follows.
REQ-033 SHALL cover: Data_Valid held high continuously with P_DATA=0x55, PAR_EN=0 -> back-to-back frames separated by exactly one idle-high cycle.
REQ-034 SHALL cover: rst pulsed low at cycle 5 of a frame -> TX_OUT=1 and Busy=0 immediately; next Data_Valid with 0x81 -> complete, correct frame.
